// File: rtl/hit_formatter.sv
// Pixel hit formatter: Gray-decodes LE/TE, computes ToT, packs a 32-bit word into a FWFT FIFO.
// Latency: in_strobe at cycle N gives out_valid at N+2 when the FIFO is empty.
// Backpressure: out_ready stalls the FIFO head; writes into a full FIFO without a pop are dropped and counted.
module hit_formatter #(
   parameter int DEPTH = 16
) (
   input  logic        clk_bx,
   input  logic        reset,
   input  logic [26:0] in_data,
   input  logic        in_strobe,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        fifo_full,
   output logic        fifo_empty,
   output logic [7:0]  overflow_cnt,
   output logic [15:0] hit_cnt
);

   localparam int AW = $clog2(DEPTH);

   // Gray to binary: MSB passes through, each lower bit folds in the bit above.
   function automatic logic [5:0] gray2bin(input logic [5:0] g);
      logic [5:0] b;
      b[5] = g[5];
      for (int i = 4; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic          s1_vld_q, s1_vld_d;
   logic [31:0]   s1_word_q, s1_word_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          ovf_flag_q, ovf_flag_d;
   logic [7:0]    ovf_cnt_q, ovf_cnt_d;
   logic [15:0]   hit_cnt_q, hit_cnt_d;
   logic [31:0]   mem [DEPTH];

   logic [5:0]    le_bin;
   logic [5:0]    te_bin;
   logic [5:0]    tot;
   logic          pop;
   logic          push;
   logic          drop;

   // Stage-1 decode and word build; the ovf bit is merged later at FIFO write time.
   always_comb begin
      le_bin    = gray2bin(in_data[11:6]);
      te_bin    = gray2bin(in_data[5:0]);
      tot       = te_bin - le_bin;
      s1_vld_d  = in_strobe;
      s1_word_d = s1_word_q;
      if (in_strobe) begin
         s1_word_d = {2'b01, in_data[26:21], in_data[20:12], le_bin, tot, 1'b0, 2'b00};
      end
   end

   // FIFO control: a full FIFO still accepts a write when the head is popped in the same cycle.
   always_comb begin
      pop        = !empty_q && out_ready;
      push       = s1_vld_q && (!full_q || pop);
      drop       = s1_vld_q && full_q && !pop;
      wr_ptr_d   = wr_ptr_q + (push ? 1'b1 : 1'b0);
      rd_ptr_d   = rd_ptr_q + (pop ? 1'b1 : 1'b0);
      cnt_d      = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!push && pop) begin
         cnt_d = cnt_q - 1'b1;
      end
      full_d     = (cnt_d == (AW+1)'(DEPTH));
      empty_d    = (cnt_d == '0);
      ovf_flag_d = ovf_flag_q;
      if (drop) begin
         ovf_flag_d = 1'b1;
      end else if (push) begin
         ovf_flag_d = 1'b0;
      end
      ovf_cnt_d  = ovf_cnt_q;
      if (drop && ovf_cnt_q != 8'hFF) begin
         ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
      hit_cnt_d  = hit_cnt_q + (in_strobe ? 16'd1 : 16'd0);
   end

   // State registers with synchronous reset; a strobe coincident with reset is discarded.
   always_ff @(posedge clk_bx) begin
      if (reset) begin
         s1_vld_q   <= 1'b0;
         s1_word_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         ovf_flag_q <= 1'b0;
         ovf_cnt_q  <= '0;
         hit_cnt_q  <= '0;
      end else begin
         s1_vld_q   <= s1_vld_d;
         s1_word_q  <= s1_word_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         ovf_flag_q <= ovf_flag_d;
         ovf_cnt_q  <= ovf_cnt_d;
         hit_cnt_q  <= hit_cnt_d;
      end
   end

   // Storage array carries the sticky overflow flag into bit 2 of the written word.
   always_ff @(posedge clk_bx) begin
      if (push) begin
         mem[wr_ptr_q[AW-1:0]] <= {s1_word_q[31:3], ovf_flag_q, s1_word_q[1:0]};
      end
   end

   // First-word-fall-through head; forced to zero while empty so reset shows out_data=0.
   always_comb begin
      out_valid    = !empty_q;
      out_data     = empty_q ? 32'd0 : mem[rd_ptr_q[AW-1:0]];
      fifo_full    = full_q;
      fifo_empty   = empty_q;
      overflow_cnt = ovf_cnt_q;
      hit_cnt      = hit_cnt_q;
   end

endmodule

// File: tb/tb_hit_formatter.sv
// Directed bench for hit_formatter: latency, Gray/ToT math, backpressure, overflow, saturation, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected words are built from hand-decoded field values.
module tb_hit_formatter;

   localparam int DEPTH = 16;

   logic        clk_bx = 1'b0;
   logic        reset;
   logic [26:0] in_data;
   logic        in_strobe;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  overflow_cnt;
   logic [15:0] hit_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk_bx = ~clk_bx;

   hit_formatter #(.DEPTH(DEPTH)) dut (
      .clk_bx       (clk_bx),
      .reset        (reset),
      .in_data      (in_data),
      .in_strobe    (in_strobe),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .overflow_cnt (overflow_cnt),
      .hit_cnt      (hit_cnt)
   );

   task automatic tick();
      @(posedge clk_bx);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fmt(input logic [5:0] col, input logic [8:0] row,
                                       input logic [5:0] le, input logic [5:0] tot,
                                       input logic ovf);
      return {2'b01, col, row, le, tot, ovf, 2'b00};
   endfunction

   task automatic strobe(input logic [5:0] col, input logic [8:0] row,
                         input logic [5:0] leg, input logic [5:0] teg);
      in_data   = {col, row, leg, teg};
      in_strobe = 1'b1;
   endtask

   initial begin
      reset     = 1'b1;
      in_data   = '0;
      in_strobe = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_valid",  32'(out_valid),    32'd0);
      check("rst_empty",  32'(fifo_empty),   32'd1);
      check("rst_full",   32'(fifo_full),    32'd0);
      check("rst_data",   out_data,          32'd0);
      check("rst_ovfcnt", 32'(overflow_cnt), 32'd0);
      check("rst_hitcnt", 32'(hit_cnt),      32'd0);
      reset = 1'b0;

      // Single hit: LE gray 000011 -> 2, TE gray 000110 -> 4, tot 2
      strobe(6'd5, 9'd100, 6'b000011, 6'b000110);
      tick();
      in_strobe = 1'b0;
      in_data   = 27'h7FFFFFF;   // ignored while strobe low
      check("single_n1_valid", 32'(out_valid), 32'd0);
      tick();
      check("single_n2_valid", 32'(out_valid), 32'd1);
      check("single_word", out_data, fmt(6'd5, 9'd100, 6'd2, 6'd2, 1'b0));
      check("single_hitcnt", 32'(hit_cnt), 32'd1);
      out_ready = 1'b1;
      tick();
      check("single_popped_empty", 32'(fifo_empty), 32'd1);

      // Wrapping ToT: LE gray 100001 -> 62, TE gray 000001 -> 1, tot 3
      strobe(6'd63, 9'd511, 6'b100001, 6'b000001);
      tick();
      in_strobe = 1'b0;
      tick();
      check("wrap_valid", 32'(out_valid), 32'd1);
      check("wrap_word", out_data, fmt(6'd63, 9'd511, 6'd62, 6'd3, 1'b0));
      tick();
      check("wrap_drained", 32'(fifo_empty), 32'd1);

      // Backpressure: DEPTH+3 back-to-back strobes, last three dropped
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         strobe(6'(i), 9'(i * 3), 6'd0, 6'd0);
         tick();
      end
      in_strobe = 1'b0;
      tick();
      tick();
      check("bp_full",   32'(fifo_full),    32'd1);
      check("bp_ovfcnt", 32'(overflow_cnt), 32'd3);
      check("bp_hitcnt", 32'(hit_cnt),      32'(2 + DEPTH + 3));
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("bp_word%0d", i), out_data, fmt(6'(i), 9'(i * 3), 6'd0, 6'd0, 1'b0));
         check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
         tick();
      end
      check("bp_empty_after", 32'(fifo_empty), 32'd1);
      // Sticky flag lands on the next written word only
      strobe(6'd40, 9'd7, 6'b000011, 6'b000110);
      tick();
      strobe(6'd41, 9'd8, 6'b000011, 6'b000110);
      tick();
      in_strobe = 1'b0;
      check("ovf_first",  out_data, fmt(6'd40, 9'd7, 6'd2, 6'd2, 1'b1));
      tick();
      check("ovf_second", out_data, fmt(6'd41, 9'd8, 6'd2, 6'd2, 1'b0));
      tick();
      check("ovf_drained", 32'(fifo_empty), 32'd1);

      // Full with simultaneous pop: write accepted, no drop
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         strobe(6'(i), 9'(200 + i), 6'd0, 6'd0);
         tick();
      end
      in_strobe = 1'b0;
      tick();
      tick();
      check("fp_full_before", 32'(fifo_full), 32'd1);
      strobe(6'd50, 9'd300, 6'd0, 6'd0);
      tick();
      in_strobe = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("fp_ovfcnt", 32'(overflow_cnt), 32'd3);
      check("fp_full",   32'(fifo_full),    32'd1);
      check("fp_head",   out_data, fmt(6'd1, 9'd201, 6'd0, 6'd0, 1'b0));
      out_ready = 1'b1;
      for (int i = 1; i < DEPTH; i++) begin
         check($sformatf("fp_word%0d", i), out_data, fmt(6'(i), 9'(200 + i), 6'd0, 6'd0, 1'b0));
         tick();
      end
      check("fp_new_word", out_data, fmt(6'd50, 9'd300, 6'd0, 6'd0, 1'b0));
      tick();
      check("fp_empty", 32'(fifo_empty), 32'd1);

      // Saturation: fill, then 300 drops on top of the 3 already counted
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH + 300; i++) begin
         strobe(6'(i), 9'(i), 6'd0, 6'd0);
         tick();
      end
      in_strobe = 1'b0;
      tick();
      tick();
      check("sat_ovfcnt", 32'(overflow_cnt), 32'd255);

      // Reset mid-stream with a word in stage 1 and a strobe during reset
      strobe(6'd9, 9'd9, 6'd0, 6'd0);
      tick();
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      in_strobe = 1'b0;
      check("mid_rst_valid",  32'(out_valid),    32'd0);
      check("mid_rst_empty",  32'(fifo_empty),   32'd1);
      check("mid_rst_full",   32'(fifo_full),    32'd0);
      check("mid_rst_ovfcnt", 32'(overflow_cnt), 32'd0);
      check("mid_rst_hitcnt", 32'(hit_cnt),      32'd0);
      tick();
      check("mid_rst_flush", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      strobe(6'd12, 9'd34, 6'b000011, 6'b000001);
      tick();
      in_strobe = 1'b0;
      check("post_rst_n1", 32'(out_valid), 32'd0);
      tick();
      check("post_rst_n2",   32'(out_valid), 32'd1);
      // LE gray 000011 -> 2, TE gray 000001 -> 1, tot = 63; sticky flag cleared by reset
      check("post_rst_word", out_data, fmt(6'd12, 9'd34, 6'd2, 6'd63, 1'b0));
      check("post_rst_hit",  32'(hit_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
